// File: rtl/branch_pc_unit_pkg.sv
// Shared definitions for the branch/PC unit.
//   pc_state_t : sequencing state of the PC unit
//   br_cond_t  : branch condition encoding carried in the instruction
//   cond_met() : evaluates a branch condition against the registered flags
package branch_pc_unit_pkg;

  localparam int PC_W_DEFAULT   = 10;
  localparam int LUT_AW_DEFAULT = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

  typedef enum logic [1:0] {
    BR_ALW = 2'b00,
    BR_EQ  = 2'b01,
    BR_NE  = 2'b10,
    BR_LT  = 2'b11
  } br_cond_t;

  function automatic logic cond_met(br_cond_t cond, logic zflag, logic nflag);
    logic met;
    case (cond)
      BR_ALW:  met = 1'b1;
      BR_EQ:   met = zflag;
      BR_NE:   met = ~zflag;
      BR_LT:   met = nflag;
      default: met = 1'b0;
    endcase
    return met;
  endfunction

endpackage

// File: rtl/branch_pc_unit_if.sv
// Control/status bundle for branch_pc_unit.
//   master : instruction decode / loader side (drives control and LUT writes)
//   slave  : the PC unit (returns PC, Taken, flags and Done)
interface branch_pc_unit_if
  import branch_pc_unit_pkg::*;
#(
  parameter int PC_W   = PC_W_DEFAULT,
  parameter int LUT_AW = LUT_AW_DEFAULT
);

  logic              Start;
  logic [PC_W-1:0]   StartAddr;
  logic              FlagWrite;
  logic              ZeroIn;
  logic              NegIn;
  logic              Branch;
  logic [1:0]        BrCond;
  logic [LUT_AW-1:0] BrIdx;
  logic              Halt;
  logic              LutWe;
  logic [LUT_AW-1:0] LutAddr;
  logic [PC_W-1:0]   LutData;
  logic [PC_W-1:0]   PC;
  logic              Taken;
  logic              ZFlag;
  logic              NFlag;
  logic              Done;

  modport master (
    output Start, StartAddr, FlagWrite, ZeroIn, NegIn, Branch, BrCond, BrIdx,
           Halt, LutWe, LutAddr, LutData,
    input  PC, Taken, ZFlag, NFlag, Done
  );

  modport slave (
    input  Start, StartAddr, FlagWrite, ZeroIn, NegIn, Branch, BrCond, BrIdx,
           Halt, LutWe, LutAddr, LutData,
    output PC, Taken, ZFlag, NFlag, Done
  );

endinterface

// File: rtl/branch_pc_unit_lut.sv
// Branch-target lookup table: 2**LUT_AW entries of PC_W bits.
//   clk   : write clock
//   we    : write enable, waddr/wdata written on the rising edge
//   raddr : asynchronous read index, rdata returns the pre-edge contents
// Contents are deliberately not reset.
module branch_lut #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [LUT_AW-1:0] waddr,
  input  logic [PC_W-1:0]   wdata,
  input  logic [LUT_AW-1:0] raddr,
  output logic [PC_W-1:0]   rdata
);

  logic [PC_W-1:0] mem [2**LUT_AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/branch_pc_unit.sv
// Program-counter sequencer with flag-conditioned branches through a target LUT.
//   Clk, Reset : clock and asynchronous active-high reset
//   bus        : slave side of branch_pc_unit_if
//                inputs  Start/StartAddr, FlagWrite/ZeroIn/NegIn,
//                        Branch/BrCond/BrIdx, Halt, LutWe/LutAddr/LutData
//                outputs PC, Taken (combinational), ZFlag, NFlag, Done
module branch_pc_unit
  import branch_pc_unit_pkg::*;
#(
  parameter int PC_W   = PC_W_DEFAULT,
  parameter int LUT_AW = LUT_AW_DEFAULT
) (
  input  logic       Clk,
  input  logic       Reset,
  branch_pc_unit_if.slave bus
);

  pc_state_t       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            zflag_q, zflag_d;
  logic            nflag_q, nflag_d;
  logic            done_q, done_d;
  logic            taken;
  logic [PC_W-1:0] lut_rdata;

  branch_lut #(
    .PC_W   (PC_W),
    .LUT_AW (LUT_AW)
  ) u_lut (
    .clk   (Clk),
    .we    (bus.LutWe),
    .waddr (bus.LutAddr),
    .wdata (bus.LutData),
    .raddr (bus.BrIdx),
    .rdata (lut_rdata)
  );

  // Only the registered flags feed the condition, so a compare and a branch
  // in the same cycle resolve against the previous compare result.
  assign taken = (state_q == RUN) && bus.Branch
                 && cond_met(br_cond_t'(bus.BrCond), zflag_q, nflag_q);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    zflag_d = zflag_q;
    nflag_d = nflag_q;

    if (state_q == RUN && bus.FlagWrite) begin
      zflag_d = bus.ZeroIn;
      nflag_d = bus.NegIn;
    end

    if (bus.Start) begin
      state_d = RUN;
      pc_d    = bus.StartAddr;
    end else if (state_q == RUN) begin
      if (bus.Halt) begin
        state_d = HALTED;
      end else if (taken) begin
        pc_d = lut_rdata;
      end else begin
        pc_d = pc_q + PC_W'(1);
      end
    end

    done_d = (state_d == HALTED);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      zflag_q <= 1'b0;
      nflag_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      zflag_q <= zflag_d;
      nflag_q <= nflag_d;
      done_q  <= done_d;
    end
  end

  assign bus.PC    = pc_q;
  assign bus.Taken = taken;
  assign bus.ZFlag = zflag_q;
  assign bus.NFlag = nflag_q;
  assign bus.Done  = done_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
module tb_branch_pc_unit;

  localparam int PCW   = 10;
  localparam int NLUT  = 32;
  localparam int PCMOD = 1 << PCW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_pc_unit_if bus ();

  branch_pc_unit dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  typedef struct {
    int pc;
    bit z;
    bit n;
    bit done;
  } exp_t;

  exp_t q_state[$];
  bit   q_taken[$];

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: plain arithmetic on integers
  bit m_run, m_halted, m_z, m_n;
  int m_pc;
  int m_lut[NLUT];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.Start = 0; bus.StartAddr = '0; bus.FlagWrite = 0; bus.ZeroIn = 0;
    bus.NegIn = 0; bus.Branch = 0; bus.BrCond = '0; bus.BrIdx = '0;
    bus.Halt = 0; bus.LutWe = 0; bus.LutAddr = '0; bus.LutData = '0;
  endtask

  // Called at posedge+2 with inputs already driven; predicts, then advances one cycle.
  task automatic step();
    bit   cond, tk, was_run;
    exp_t e;
    case (int'(bus.BrCond))
      0:       cond = 1;
      1:       cond = m_z;
      2:       cond = !m_z;
      default: cond = m_n;
    endcase
    was_run = m_run;
    tk = m_run && bus.Branch && cond;
    if (bus.Start) begin
      m_run = 1; m_halted = 0; m_pc = int'(bus.StartAddr);
    end else if (m_run) begin
      if (bus.Halt) begin
        m_run = 0; m_halted = 1;
      end else if (tk) begin
        m_pc = m_lut[int'(bus.BrIdx)];
      end else begin
        m_pc = (m_pc + 1) % PCMOD;
      end
    end
    if (was_run && bus.FlagWrite) begin
      m_z = bus.ZeroIn; m_n = bus.NegIn;
    end
    if (bus.LutWe) m_lut[int'(bus.LutAddr)] = int'(bus.LutData);
    e.pc = m_pc; e.z = m_z; e.n = m_n; e.done = m_halted;
    q_taken.push_back(tk);
    q_state.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) begin
      clear_inputs();
      step();
    end
  endtask

  task automatic do_start(input int addr);
    clear_inputs();
    bus.Start = 1; bus.StartAddr = PCW'(addr);
    step();
  endtask

  // Asserted between edges: outputs must clear without waiting for a clock.
  task automatic do_reset();
    rst = 1;
    #1;
    chk("reset_pc", int'(bus.PC), 0);
    chk("reset_zflag", int'(bus.ZFlag), 0);
    chk("reset_nflag", int'(bus.NFlag), 0);
    chk("reset_done", int'(bus.Done), 0);
    chk("reset_taken", int'(bus.Taken), 0);
    m_run = 0; m_halted = 0; m_pc = 0; m_z = 0; m_n = 0;
    @(posedge clk);
    #1;
    rst = 0;
    #1;
  endtask

  // monitors
  initial begin
    forever begin
      @(negedge clk);
      if (q_taken.size() > 0) chk("taken", int'(bus.Taken), int'(q_taken.pop_front()));
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_state.size() > 0) begin
        e = q_state.pop_front();
        chk("pc", int'(bus.PC), e.pc);
        chk("zflag", int'(bus.ZFlag), int'(e.z));
        chk("nflag", int'(bus.NFlag), int'(e.n));
        chk("done", int'(bus.Done), int'(e.done));
      end
    end
  end

  initial begin
    clear_inputs();
    m_run = 0; m_halted = 0; m_pc = 0; m_z = 0; m_n = 0;
    for (int i = 0; i < NLUT; i++) m_lut[i] = 0;
    @(posedge clk);
    #2;
    do_reset();

    // load every LUT entry while idle; PC must hold at 0
    for (int i = 0; i < NLUT; i++) begin
      clear_inputs();
      bus.LutWe = 1; bus.LutAddr = 5'(i);
      bus.LutData = (i == 3) ? 10'h200 : PCW'($urandom_range(PCMOD - 1));
      bus.Branch = 1; bus.Halt = ($urandom_range(1) == 1); bus.FlagWrite = 1; bus.ZeroIn = 1;
      step();
    end

    // sequential fetch from 0x010
    do_start(10'h010);
    idle_steps(4);

    // compare then taken branch through LUT[3]
    clear_inputs(); bus.FlagWrite = 1; bus.ZeroIn = 1; step();
    clear_inputs(); bus.Branch = 1; bus.BrCond = 2'b01; bus.BrIdx = 5'd3; step();

    // compare and branch in the same cycle see the old flag
    clear_inputs(); bus.FlagWrite = 1; bus.ZeroIn = 0; step();
    clear_inputs(); bus.FlagWrite = 1; bus.ZeroIn = 1;
    bus.Branch = 1; bus.BrCond = 2'b01; bus.BrIdx = 5'd3; step();
    idle_steps(1);

    // wrap at the top of the address space, halt, restart
    do_start(10'h3FE);
    idle_steps(2);
    clear_inputs(); bus.Halt = 1; step();
    for (int i = 0; i < 5; i++) begin
      clear_inputs(); bus.Branch = 1; bus.Halt = 1; bus.FlagWrite = 1; bus.NegIn = 1; step();
    end
    do_start(10'h040);
    idle_steps(1);

    // reset in the middle of a run at 0x123
    do_start(10'h120);
    idle_steps(3);
    do_reset();
    idle_steps(3);

    // start and halt together restart instead of halting
    do_start(10'h055);
    idle_steps(1);
    clear_inputs(); bus.Start = 1; bus.Halt = 1; bus.StartAddr = 10'h0AA; step();
    idle_steps(2);

    // randomized phase
    for (int it = 0; it < 1500; it++) begin
      if ($urandom_range(199) == 0) begin
        do_reset();
      end else begin
        clear_inputs();
        bus.Start     = ($urandom_range(99) < 3);
        bus.StartAddr = PCW'($urandom_range(PCMOD - 1));
        bus.FlagWrite = ($urandom_range(99) < 25);
        bus.ZeroIn    = $urandom_range(1) == 1;
        bus.NegIn     = $urandom_range(1) == 1;
        bus.Branch    = ($urandom_range(99) < 35);
        bus.BrCond    = 2'($urandom_range(3));
        bus.BrIdx     = 5'($urandom_range(NLUT - 1));
        bus.Halt      = ($urandom_range(99) < 3);
        bus.LutWe     = ($urandom_range(99) < 15);
        bus.LutAddr   = ($urandom_range(3) == 0) ? bus.BrIdx : 5'($urandom_range(NLUT - 1));
        bus.LutData   = PCW'($urandom_range(PCMOD - 1));
        step();
      end
    end

    clear_inputs();
    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_drained", q_state.size() + q_taken.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
